// File: rtl/adc_pkg.sv
// Shared types and sizing helpers for the serial ADC capture block.
// ADC_CAPTURE_PARITY_EN adds one even-parity bit to every frame.
package adc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef ADC_CAPTURE_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Counter/tag width for n distinct values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/adc_shift_capture_if.sv
// Readout side of the ADC capture block: completed word, tag and valid/ready handshake.
interface adc_shift_capture_if #(
    parameter int WIDTH = 10,
    parameter int CW    = 1
);
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    out_chan;
    logic             out_valid;
    logic             out_ready;
    logic             out_perr;

    modport master (
        output out, out_chan, out_valid, out_perr,
        input  out_ready
    );

    modport slave (
        input  out, out_chan, out_valid, out_perr,
        output out_ready
    );
endinterface

// File: rtl/adc_frame_counter.sv
// Bit position counter for one serial frame; done pulses while the final bit is sampled.
module adc_frame_counter
    import adc_pkg::*;
#(
    parameter int FRAME_LEN = 10,
    parameter int BW        = width_of(FRAME_LEN)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic advance,
    input  logic restart,
    input  logic clear,
    output logic done
);

    logic [BW-1:0] count;

    // restart loads 1 because the restarting cycle already samples bit 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (restart) begin
            count <= BW'(1);
        end else if (advance) begin
            count <= count + BW'(1);
        end
    end

    assign done = advance && (count == BW'(FRAME_LEN - 1));

endmodule

// File: rtl/adc_shift_capture.sv
// Deserialises framed ADC bits into WIDTH-bit words with channel tag, handshake and overrun.
// Define ADC_CAPTURE_PARITY_EN for an extra even-parity bit per frame and out_perr.
//
// state | meaning
// IDLE  | waiting for enable & start
// SHIFT | sampling the remaining bits of a frame
module adc_shift_capture
    import adc_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int CHANNELS  = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic start,
    input  logic in,
    input  logic clr_ovr,
    output logic busy,
    output logic overrun,
    adc_shift_capture_if.master rd
);

    localparam int CW        = width_of(CHANNELS);
    localparam int FRAME_LEN = frame_len(WIDTH);

    state_t               state, state_nxt;
    logic                 load_first, complete, cnt_clear, advance;
    logic [FRAME_LEN-1:0] shreg, frame_word, first_word;
    logic [WIDTH-1:0]     word_data;
    logic [CW-1:0]        chan_cnt;
    logic                 load_word, drop_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable && start) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (!enable) state_nxt = IDLE;
                else if (complete && !start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // start inside a frame always reloads bit 0; on the final bit it also chains a new frame
    always_comb begin
        load_first = 1'b0;
        cnt_clear  = 1'b0;
        case (state)
            IDLE: begin
                load_first = enable && start;
            end
            SHIFT: begin
                if (!enable) begin
                    cnt_clear = 1'b1;
                end else begin
                    load_first = start;
                    cnt_clear  = complete && !start;
                end
            end
            default: cnt_clear = 1'b1;
        endcase
    end

    assign advance = (state == SHIFT) && enable;
    assign busy    = (state == SHIFT);

    adc_frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (advance),
        .restart (load_first),
        .clear   (cnt_clear),
        .done    (complete)
    );

    always_comb begin
        if (MSB_FIRST != 0) begin
            frame_word = {shreg[FRAME_LEN-2:0], in};
            first_word = {{(FRAME_LEN-1){1'b0}}, in};
            word_data  = frame_word[FRAME_LEN-1 -: WIDTH];
        end else begin
            frame_word = {in, shreg[FRAME_LEN-1:1]};
            first_word = {in, {(FRAME_LEN-1){1'b0}}};
            word_data  = frame_word[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
        end else if (load_first) begin
            shreg <= first_word;
        end else if (advance) begin
            shreg <= frame_word;
        end
    end

    assign drop_word = complete && rd.out_valid && !rd.out_ready;
    assign load_word = complete && !drop_word;

    // Dropped words still advance the tag so later words stay channel-aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_cnt     <= '0;
            rd.out       <= '0;
            rd.out_chan  <= '0;
            rd.out_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (complete) begin
                chan_cnt <= (chan_cnt == CW'(CHANNELS - 1)) ? '0 : chan_cnt + CW'(1);
            end
            if (load_word) begin
                rd.out       <= word_data;
                rd.out_chan  <= chan_cnt;
                rd.out_valid <= 1'b1;
            end else if (rd.out_valid && rd.out_ready) begin
                rd.out_valid <= 1'b0;
            end
            if (drop_word) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef ADC_CAPTURE_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd.out_perr <= 1'b0;
        end else if (load_word) begin
            rd.out_perr <= ^frame_word;
        end
    end
`else
    assign rd.out_perr = 1'b0;
`endif

endmodule

// File: tb/tb_adc_shift_capture.sv
// Directed bench: MSB-first and LSB-first instances share one serial stimulus stream.
module tb_adc_shift_capture;

    localparam int W   = 10;
    localparam int CH  = 3;
    localparam int CWT = 2;
`ifdef ADC_CAPTURE_PARITY_EN
    localparam int   FL       = W + 1;
    localparam logic PERR_BAD = 1'b1;
`else
    localparam int   FL       = W;
    localparam logic PERR_BAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n, enable, start, sdata, clr_ovr;
    logic busy_m, busy_l, ovr_m, ovr_l;
    logic valid_before_last;
    int   n_cmp = 0;
    int   n_bad = 0;

    adc_shift_capture_if #(.WIDTH(W), .CW(CWT)) if_m ();
    adc_shift_capture_if #(.WIDTH(W), .CW(CWT)) if_l ();

    adc_shift_capture #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(1)) dut_m (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .start   (start),
        .in      (sdata),
        .clr_ovr (clr_ovr),
        .busy    (busy_m),
        .overrun (ovr_m),
        .rd      (if_m.master)
    );

    adc_shift_capture #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(0)) dut_l (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .start   (start),
        .in      (sdata),
        .clr_ovr (clr_ovr),
        .busy    (busy_l),
        .overrun (ovr_l),
        .rd      (if_l.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ready(input logic r);
        if_m.out_ready = r;
        if_l.out_ready = r;
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] em, input logic [W-1:0] el,
                              input logic [CWT-1:0] ech, input logic ev);
        check({tag, ".out_m"},   32'(if_m.out),       32'(em));
        check({tag, ".out_l"},   32'(if_l.out),       32'(el));
        check({tag, ".chan_m"},  32'(if_m.out_chan),  32'(ech));
        check({tag, ".chan_l"},  32'(if_l.out_chan),  32'(ech));
        check({tag, ".valid_m"}, 32'(if_m.out_valid), 32'(ev));
        check({tag, ".valid_l"}, 32'(if_l.out_valid), 32'(ev));
    endtask

    task automatic check_status(input string tag, input logic eb, input logic eo);
        check({tag, ".busy_m"}, 32'(busy_m), 32'(eb));
        check({tag, ".busy_l"}, 32'(busy_l), 32'(eb));
        check({tag, ".ovr_m"},  32'(ovr_m),  32'(eo));
        check({tag, ".ovr_l"},  32'(ovr_l),  32'(eo));
    endtask

    // Sends s first-bit-first (s[W-1] leads), then the parity bit when frames carry one.
    task automatic send_frame(input logic [W-1:0] s, input logic p, input logic rdy_last);
        logic [W:0] f;
        f = {s, p};
        for (int i = 0; i < FL; i++) begin
            if (i == FL - 1) begin
                valid_before_last = if_m.out_valid;
                if (rdy_last) set_ready(1'b1);
            end
            start = (i == 0);
            sdata = f[W - i];
            tick();
        end
        start = 1'b0;
        sdata = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        start   = 1'b0;
        sdata   = 1'b0;
        clr_ovr = 1'b0;
        valid_before_last = 1'b0;
        set_ready(1'b0);
        tick();
        tick();

        check_word("reset", 10'h000, 10'h000, 2'd0, 1'b0);
        check_status("reset", 1'b0, 1'b0);
        check("reset.perr_m", 32'(if_m.out_perr), 32'(0));
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();

        // Ordering and latency
        send_frame(10'h2CE, 1'b0, 1'b0);
        check("order.latency_pre", 32'(valid_before_last), 32'(0));
        check_word("order", 10'h2CE, 10'h1CD, 2'd0, 1'b1);
        check_status("order", 1'b0, 1'b0);
        check("order.perr_m", 32'(if_m.out_perr), 32'(0));
        check("order.perr_l", 32'(if_l.out_perr), 32'(0));

        // Second frame with no consumer: dropped, overrun set, held word untouched
        send_frame(10'h3F0, 1'b0, 1'b0);
        check_word("ovr", 10'h2CE, 10'h1CD, 2'd0, 1'b1);
        check_status("ovr", 1'b0, 1'b1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check_word("clr", 10'h2CE, 10'h1CD, 2'd0, 1'b1);
        check_status("clr", 1'b0, 1'b0);

        set_ready(1'b1);
        tick();
        check("consume.valid_m", 32'(if_m.out_valid), 32'(0));
        set_ready(1'b0);

        // Tag skipped channel 1 because the dropped word consumed it
        send_frame(10'h155, 1'b1, 1'b0);
        check_word("f3", 10'h155, 10'h2AA, 2'd2, 1'b1);
        check("f3.perr_m", 32'(if_m.out_perr), 32'(0));

        // Ready on the completion cycle: old word consumed, new word loaded, no overrun
        send_frame(10'h00F, 1'b0, 1'b1);
        check_word("f4", 10'h00F, 10'h3C0, 2'd0, 1'b1);
        check_status("f4", 1'b0, 1'b0);
        tick();
        check("f4.consume_l", 32'(if_l.out_valid), 32'(0));
        set_ready(1'b0);

        // Abort after 4 bits
        for (int i = 0; i < 4; i++) begin
            start = (i == 0);
            sdata = 1'b1;
            tick();
        end
        start = 1'b0;
        check("abort.busy_pre", 32'(busy_m), 32'(1));
        enable = 1'b0;
        tick();
        check_word("abort", 10'h00F, 10'h3C0, 2'd0, 1'b0);
        check_status("abort", 1'b0, 1'b0);
        enable = 1'b1;
        tick();

        // Resync: 6 junk bits, then start reloads bit 0
        for (int i = 0; i < 6; i++) begin
            start = (i == 0);
            sdata = 1'b1;
            tick();
        end
        send_frame(10'h0A5, 1'b0, 1'b0);
        check("resync.latency_pre", 32'(valid_before_last), 32'(0));
        check_word("resync", 10'h0A5, 10'h294, 2'd1, 1'b1);
        check_status("resync", 1'b0, 1'b0);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) begin
            start = (i == 0);
            sdata = 1'b1;
            tick();
        end
        start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_word("areset", 10'h000, 10'h000, 2'd0, 1'b0);
        check_status("areset", 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

        // Five chained frames; completion bit doubles as the next frame's bit 0
        set_ready(1'b1);
        start = 1'b1;
        sdata = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            for (int j = 1; j < FL; j++) begin
                start = (j == FL - 1) && (k < 4);
                tick();
                if (j < FL - 1 || k < 4) check("b2b.busy", 32'(busy_m), 32'(1));
            end
            check_word("b2b", 10'h3FF, 10'h3FF, 2'(k % CH), 1'b1);
        end
        start = 1'b0;
        check("b2b.busy_end", 32'(busy_l), 32'(0));
        tick();
        set_ready(1'b0);

        // Wrong parity bit; only flagged when frames carry parity
        send_frame(10'h2CE, 1'b1, 1'b0);
        check("par.latency_pre", 32'(valid_before_last), 32'(0));
        check_word("par", 10'h2CE, 10'h1CD, 2'd2, 1'b1);
        check("par.perr_m", 32'(if_m.out_perr), 32'(PERR_BAD));
        check("par.perr_l", 32'(if_l.out_perr), 32'(PERR_BAD));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
